// File: rtl/ysyx_24070014_demux_pkg.sv
// ysyx_24070014_demux_pkg: shared state encoding and index-width helper for the keyed demux.
package ysyx_24070014_demux_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    function automatic int IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ysyx_24070014_key_match.sv
// ysyx_24070014_key_match: combinational key lookup; the lowest matching port index wins.
module ysyx_24070014_key_match
    import ysyx_24070014_demux_pkg::*;
#(
    parameter int NR_PORT = 4,
    parameter int KEY_LEN = 2,
    parameter int IW      = IDX_W(NR_PORT)
) (
    input  logic [KEY_LEN-1:0]         i_key,
    input  logic [NR_PORT*KEY_LEN-1:0] i_key_list,
    output logic                       o_hit,
    output logic [IW-1:0]              o_idx
);

    // Scan from the top down so the last (lowest) match overwrites higher ones.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = NR_PORT - 1; i >= 0; i--) begin
            if (i_key == i_key_list[i*KEY_LEN +: KEY_LEN]) begin
                o_hit = 1'b1;
                o_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/ysyx_24070014_key_demux.sv
// ysyx_24070014_key_demux: keyed 1-to-NR_PORT valid/ready demux with a 1-entry register slice.
// Define YSYX_24070014_DEMUX_MISS_CNT_EN to add the saturating 16-bit miss_cnt output.
module ysyx_24070014_key_demux
    import ysyx_24070014_demux_pkg::*;
#(
    parameter int NR_PORT  = 4,
    parameter int KEY_LEN  = 2,
    parameter int DATA_LEN = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [KEY_LEN-1:0]         in_key,
    input  logic [DATA_LEN-1:0]        in_data,
    input  logic [NR_PORT*KEY_LEN-1:0] key_list,
    output logic [NR_PORT-1:0]         out_valid,
    input  logic [NR_PORT-1:0]         out_ready,
    output logic [DATA_LEN-1:0]        out_data,
`ifdef YSYX_24070014_DEMUX_MISS_CNT_EN
    output logic [15:0]                miss_cnt,
`endif
    output logic                       miss
);

    localparam int IW = IDX_W(NR_PORT);

    state_t              r_state;
    state_t              w_state_n;
    logic [IW-1:0]       r_sel;
    logic [DATA_LEN-1:0] r_data;
    logic                r_miss;
    logic                w_hit;
    logic [IW-1:0]       w_idx;
    logic                w_drain;
    logic                w_acc;

    ysyx_24070014_key_match #(
        .NR_PORT (NR_PORT),
        .KEY_LEN (KEY_LEN),
        .IW      (IW)
    ) u_match (
        .i_key      (in_key),
        .i_key_list (key_list),
        .o_hit      (w_hit),
        .o_idx      (w_idx)
    );

    // Readiness looks only at the buffered port, never at the incoming key.
    assign in_ready  = (r_state == ST_EMPTY) | out_ready[r_sel];
    assign w_drain   = (r_state == ST_FULL) & out_ready[r_sel];
    assign w_acc     = in_valid & in_ready;
    assign out_valid = (r_state == ST_FULL) ? (NR_PORT'(1) << r_sel) : '0;
    assign out_data  = r_data;
    assign miss      = r_miss;

    always_comb begin
        w_state_n = r_state;
        if (w_acc && w_hit)
            w_state_n = ST_FULL;
        else if (w_drain)
            w_state_n = ST_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_sel   <= '0;
            r_data  <= '0;
            r_miss  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_miss  <= w_acc & ~w_hit;
            if (w_acc && w_hit) begin
                r_sel  <= w_idx;
                r_data <= in_data;
            end
        end
    end

`ifdef YSYX_24070014_DEMUX_MISS_CNT_EN
    logic [15:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_miss_cnt <= '0;
        else if (w_acc && !w_hit && r_miss_cnt != 16'hFFFF)
            r_miss_cnt <= r_miss_cnt + 16'd1;
    end

    assign miss_cnt = r_miss_cnt;
`endif

endmodule
